serial_deser: RTL and testbench

Bit-serial to parallel receiver: the receiving end of the MSB-first serial stream produced by the left-shift registers in the datapath. It collects WIDTH bits into a word, presents the word on a valid/ready output port, and double-buffers so that the next word can be received while the current one waits for the consumer. It sits between a serial link or shift-out stage and the parallel consumer, such as the operand registers of the multiplier datapath.

---
 rtl/serial_deser.sv | 95 +++++++++
 tb/tb_serial_deser.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_deser.sv
// serial_deser: MSB-first bit-serial to parallel receiver with a double-buffered valid/ready word port (optional even parity: DESER_PARITY_EN)
module serial_deser #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             bit_ready,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             parity_err
);
`ifdef DESER_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int CW = $clog2(FRAME);

    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shreg, shifted, new_word, load_word;
    logic             pending, slot_free, accept, last, load, load_par;
`ifdef DESER_PARITY_EN
    logic             par, new_par;
`endif

    assign bit_ready = !pending;

    // frame completion and the decision to load the output register
    always_comb begin
        slot_free = !word_valid || word_ready;
        accept    = bit_valid && !pending;
        last      = accept && bit_cnt == CW'(FRAME - 1);
        shifted   = {shreg[WIDTH-2:0], bit_in};
`ifdef DESER_PARITY_EN
        new_word  = shreg;
        new_par   = par ^ bit_in;
        load_par  = pending ? par : new_par;
`else
        new_word  = shifted;
        load_par  = 1'b0;
`endif
        load_word = pending ? shreg : new_word;
        load      = !flush && (pending || last) && slot_free;
    end

    // shift stage, bit counter and pending flag; a finished word parks in shreg
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt <= '0;
            shreg   <= '0;
            pending <= 1'b0;
        end else if (flush) begin
            bit_cnt <= '0;
            shreg   <= '0;
            pending <= 1'b0;
        end else if (pending) begin
            pending <= !slot_free;
        end else if (accept) begin
            bit_cnt <= last ? '0 : bit_cnt + 1'b1;
            shreg   <= last ? new_word : shifted;
            pending <= last && !slot_free;
        end
    end

`ifdef DESER_PARITY_EN
    // running parity of the frame, held alongside a pending word
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            par <= 1'b0;
        else if (flush || load)
            par <= 1'b0;
        else if (accept)
            par <= new_par;
    end
`endif

    // output register: load a new word, or clear valid when consumed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_out   <= '0;
            word_valid <= 1'b0;
            parity_err <= 1'b0;
        end else if (load) begin
            word_out   <= load_word;
            word_valid <= 1'b1;
            parity_err <= load_par;
        end else if (word_ready) begin
            word_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_serial_deser.sv
// tb_serial_deser: table vectors, corner sequences and random traffic against a frame-level model
module tb_serial_deser;
    localparam int WIDTH = 16;
`ifdef DESER_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif

    logic             clk, rst, flush, bit_in, bit_valid, bit_ready, word_valid, word_ready, parity_err;
    logic [WIDTH-1:0] word_out;
    int               vectors = 0, miscompares = 0;

    serial_deser #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .flush(flush), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(bit_ready), .word_out(word_out), .word_valid(word_valid),
        .word_ready(word_ready), .parity_err(parity_err)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    bit               q[$];
    logic [WIDTH-1:0] m_pw, m_ow;
    bit               m_pp, m_op, m_ov, m_pend;

    function void model_reset();
        q.delete();
        m_pend = 0;
        m_pw   = '0;
        m_pp   = 0;
        m_ow   = '0;
        m_op   = 0;
        m_ov   = 0;
    endfunction

    function void model_edge(bit bv, bit bi, bit wr, bit fl);
        bit               free, loaded, p;
        logic [WIDTH-1:0] w;
        free   = !m_ov || wr;
        loaded = 0;
        if (fl) begin
            q.delete();
            m_pend = 0;
        end else if (m_pend) begin
            if (free) begin
                m_ow   = m_pw;
                m_op   = m_pp;
                loaded = 1;
                m_pend = 0;
            end
        end else if (bv) begin
            q.push_back(bi);
            if (q.size() == FRAME) begin
                w = '0;
                p = 0;
                for (int i = 0; i < FRAME; i++) begin
                    if (i < WIDTH) w = w * 2 + WIDTH'(q[i]);
                    p = p ^ q[i];
                end
`ifndef DESER_PARITY_EN
                p = 0;
`endif
                q.delete();
                if (free) begin
                    m_ow   = w;
                    m_op   = p;
                    loaded = 1;
                end else begin
                    m_pw   = w;
                    m_pp   = p;
                    m_pend = 1;
                end
            end
        end
        m_ov = loaded ? 1'b1 : (wr ? 1'b0 : m_ov);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("m_word_valid", 32'(word_valid), 32'(m_ov));
        chk("m_bit_ready", 32'(bit_ready), 32'(!m_pend));
        chk("m_word_out", 32'(word_out), 32'(m_ow));
        if (m_ov) chk("m_parity_err", 32'(parity_err), 32'(m_op));
    endtask

    task automatic step(input bit bv, input bit bi, input bit wr, input bit fl);
        bit_valid  = bv;
        bit_in     = bi;
        word_ready = wr;
        flush      = fl;
        @(posedge clk);
        model_edge(bv, bi, wr, fl);
        #1;
        check_model();
    endtask

    task automatic send_bits(input logic [32:0] f, input int n, input bit wr);
        for (int i = n - 1; i >= 0; i--) begin
            int waits = 0;
            while (!bit_ready && waits < 50) begin
                step(1, f[i], wr, 0);
                waits++;
            end
            if (!bit_ready) begin
                chk("bit_ready_timeout", 32'(bit_ready), 32'd1);
                return;
            end
            step(1, f[i], wr, 0);
        end
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w, input bit wr);
        logic [32:0] f;
`ifdef DESER_PARITY_EN
        f = 33'({w, ^w});
`else
        f = 33'(w);
`endif
        send_bits(f, FRAME, wr);
    endtask

    typedef struct {
        logic [WIDTH-1:0] word;
        bit               wr;
        logic [WIDTH-1:0] exp_word;
        bit               exp_valid;
        bit               exp_ready;
    } vec_t;
    vec_t tbl[5];

    initial begin
        tbl[0] = '{16'hA5C3, 1'b1, 16'hA5C3, 1'b1, 1'b1};
        tbl[1] = '{16'h1234, 1'b1, 16'h1234, 1'b1, 1'b1};
        tbl[2] = '{16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b1};
        tbl[3] = '{16'h00FF, 1'b1, 16'h00FF, 1'b1, 1'b1};
        tbl[4] = '{16'h8001, 1'b0, 16'h00FF, 1'b1, 1'b0};
        rst = 1; flush = 0; bit_in = 0; bit_valid = 0; word_ready = 0;
        model_reset();
        #12 rst = 0;
        chk("rst_word_out", 32'(word_out), 32'h0);
        chk("rst_word_valid", 32'(word_valid), 32'h0);
        chk("rst_parity_err", 32'(parity_err), 32'h0);
        chk("rst_bit_ready", 32'(bit_ready), 32'h1);
        for (int i = 0; i < 5; i++) begin
            send_word(tbl[i].word, tbl[i].wr);
            chk($sformatf("tbl%0d_word", i), 32'(word_out), 32'(tbl[i].exp_word));
            chk($sformatf("tbl%0d_valid", i), 32'(word_valid), 32'(tbl[i].exp_valid));
            chk($sformatf("tbl%0d_ready", i), 32'(bit_ready), 32'(tbl[i].exp_ready));
        end
        step(0, 0, 1, 0);
        chk("bp_release_word", 32'(word_out), 32'h8001);
        chk("bp_release_valid", 32'(word_valid), 32'h1);
        chk("bp_release_ready", 32'(bit_ready), 32'h1);
        step(0, 0, 1, 0);
        chk("consume_valid", 32'(word_valid), 32'h0);
        chk("consume_hold", 32'(word_out), 32'h8001);
        send_word(16'hA5C3, 1);
        chk("single_valid", 32'(word_valid), 32'h1);
        step(0, 0, 1, 0);
        chk("single_pulse", 32'(word_valid), 32'h0);
        send_bits(33'h55, 7, 1);
        step(1, 1, 1, 1);
        send_word(16'hBEEF, 1);
        chk("flush_word", 32'(word_out), 32'hBEEF);
        send_bits(33'h1A5, 9, 0);
        #2 rst = 1;
        #1;
        chk("arst_word_out", 32'(word_out), 32'h0);
        chk("arst_word_valid", 32'(word_valid), 32'h0);
        chk("arst_parity_err", 32'(parity_err), 32'h0);
        chk("arst_bit_ready", 32'(bit_ready), 32'h1);
        model_reset();
        #2 rst = 0;
        send_word(16'h0F0F, 1);
        chk("post_rst_word", 32'(word_out), 32'h0F0F);
        chk("post_rst_valid", 32'(word_valid), 32'h1);
`ifdef DESER_PARITY_EN
        send_bits(33'({16'hA5C3, 1'b0}), 17, 1);
        chk("par0_word", 32'(word_out), 32'hA5C3);
        chk("par0_err", 32'(parity_err), 32'h0);
        send_bits(33'({16'hA5C3, 1'b1}), 17, 1);
        chk("par1_word", 32'(word_out), 32'hA5C3);
        chk("par1_err", 32'(parity_err), 32'h1);
`endif
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 9) < 7, 1'($urandom), $urandom_range(0, 1) == 1, $urandom_range(0, 39) == 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
